// File: rtl/read_submodule.sv
// Single-beat read initiator: issues one AR handshake, waits for one R beat,
// and holds the captured data/response until the next read completes.
module read_submodule #(
   parameter int ADDR_WDTH = 4,
   parameter int DATA_WDTH = 32,
   parameter int RESP_WDTH = 1
) (
   input  logic                 clk,
   input  logic                 rst,
   output logic                 ar_valid,
   input  logic                 ar_ready,
   output logic [ADDR_WDTH-1:0] ar_address,
   input  logic                 r_valid,
   output logic                 r_ready,
   input  logic [DATA_WDTH-1:0] r_data,
   input  logic [RESP_WDTH-1:0] r_resp,
   input  logic                 start,
   input  logic [ADDR_WDTH-1:0] addr,
   output logic                 done,
   output logic [DATA_WDTH-1:0] data,
   output logic [RESP_WDTH-1:0] resp,
   output logic                 err,
   output logic                 fsm_error
);

   typedef enum logic [2:0] {
      IDLE           = 3'd0,
      SEND_AR        = 3'd1,
      WAIT_R         = 3'd2,
      PROCESS_R_RESP = 3'd3,
      FSM_ERROR      = 3'd7
   } state_e;

   // Raw 3-bit storage so the unused encodings 4-6 remain representable and detectable.
   logic [2:0]           state_q, state_d;
   logic [ADDR_WDTH-1:0] reg_addr_q, reg_addr_d;
   logic [DATA_WDTH-1:0] data_q, data_d;
   logic [RESP_WDTH-1:0] resp_q, resp_d;
   logic                 err_q, err_d;

   // Next-state and datapath update
   always_comb begin
      state_d    = state_q;
      reg_addr_d = reg_addr_q;
      data_d     = data_q;
      resp_d     = resp_q;
      err_d      = err_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d    = SEND_AR;
               reg_addr_d = addr;
               err_d      = 1'b0;
            end else begin
               state_d = IDLE;
            end
         end
         SEND_AR: begin
            if (ar_ready) begin
               state_d = WAIT_R;
            end else begin
               state_d = SEND_AR;
            end
         end
         WAIT_R: begin
            if (r_valid) begin
               state_d = PROCESS_R_RESP;
               data_d  = r_data;
               resp_d  = r_resp;
            end else begin
               state_d = WAIT_R;
            end
         end
         PROCESS_R_RESP: begin
            err_d   = (resp_q != {RESP_WDTH{1'b0}});
            state_d = IDLE;
         end
         FSM_ERROR: state_d = FSM_ERROR;
         default:   state_d = FSM_ERROR;
      endcase
   end

   // State and result registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         reg_addr_q <= {ADDR_WDTH{1'b0}};
         data_q     <= {DATA_WDTH{1'b0}};
         resp_q     <= {RESP_WDTH{1'b0}};
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         reg_addr_q <= reg_addr_d;
         data_q     <= data_d;
         resp_q     <= resp_d;
         err_q      <= err_d;
      end
   end

   assign ar_valid   = (state_q == SEND_AR);
   assign r_ready    = (state_q == WAIT_R);
   assign done       = (state_q == IDLE);
   assign fsm_error  = !((state_q == IDLE) || (state_q == SEND_AR) ||
                         (state_q == WAIT_R) || (state_q == PROCESS_R_RESP));
   assign ar_address = reg_addr_q;
   assign data       = data_q;
   assign resp       = resp_q;
   assign err        = err_q;

endmodule

// File: tb/tb_read_submodule.sv
// Directed bench for read_submodule: handshake timing, stalls, error response,
// ignored inputs, mid-transaction reset and illegal-state recovery.
module tb_read_submodule;

   logic        clk = 1'b0;
   logic        rst;
   logic        ar_valid, ar_ready;
   logic [3:0]  ar_address;
   logic        r_valid, r_ready;
   logic [31:0] r_data;
   logic [0:0]  r_resp;
   logic        start;
   logic [3:0]  addr;
   logic        done;
   logic [31:0] data;
   logic [0:0]  resp;
   logic        err, fsm_error;

   int total = 0;
   int bad   = 0;

   read_submodule #(.ADDR_WDTH(4), .DATA_WDTH(32), .RESP_WDTH(1)) dut (
      .clk(clk), .rst(rst),
      .ar_valid(ar_valid), .ar_ready(ar_ready), .ar_address(ar_address),
      .r_valid(r_valid), .r_ready(r_ready), .r_data(r_data), .r_resp(r_resp),
      .start(start), .addr(addr), .done(done), .data(data), .resp(resp),
      .err(err), .fsm_error(fsm_error)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   initial begin
      #20000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst = 1'b1; ar_ready = 1'b0; r_valid = 1'b0; r_data = 32'h0; r_resp = 1'b0;
      start = 1'b0; addr = 4'h0;
      tick(); tick();
      rst = 1'b0;
      chk("rst_done", {31'd0, done}, 32'd1);
      chk("rst_ar_valid", {31'd0, ar_valid}, 32'd0);
      chk("rst_r_ready", {31'd0, r_ready}, 32'd0);
      chk("rst_data", data, 32'h0);
      chk("rst_err", {31'd0, err}, 32'd0);
      chk("rst_fsm_error", {31'd0, fsm_error}, 32'd0);
      chk("rst_ar_address", {28'd0, ar_address}, 32'd0);

      // T1 back-to-back
      start = 1'b1; addr = 4'h5; ar_ready = 1'b1; r_valid = 1'b1;
      r_data = 32'hDEADBEEF; r_resp = 1'b0;
      tick(); start = 1'b0;
      chk("t1_c1_ar_valid", {31'd0, ar_valid}, 32'd1);
      chk("t1_c1_ar_address", {28'd0, ar_address}, 32'd5);
      chk("t1_c1_done", {31'd0, done}, 32'd0);
      tick();
      chk("t1_c2_r_ready", {31'd0, r_ready}, 32'd1);
      chk("t1_c2_ar_valid", {31'd0, ar_valid}, 32'd0);
      tick();
      chk("t1_c3_done", {31'd0, done}, 32'd0);
      chk("t1_c3_r_ready", {31'd0, r_ready}, 32'd0);
      tick();
      chk("t1_c4_done", {31'd0, done}, 32'd1);
      chk("t1_data", data, 32'hDEADBEEF);
      chk("t1_err", {31'd0, err}, 32'd0);
      ar_ready = 1'b0; r_valid = 1'b0;

      // T2 stalls
      start = 1'b1; addr = 4'h9; r_data = 32'h12345678;
      tick(); start = 1'b0; addr = 4'h3;
      for (int i = 0; i < 3; i++) begin
         chk("t2_ar_valid_stall", {31'd0, ar_valid}, 32'd1);
         chk("t2_ar_address_stall", {28'd0, ar_address}, 32'd9);
         tick();
      end
      ar_ready = 1'b1;
      chk("t2_ar_valid_last", {31'd0, ar_valid}, 32'd1);
      tick(); ar_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         chk("t2_r_ready_stall", {31'd0, r_ready}, 32'd1);
         chk("t2_ar_valid_off", {31'd0, ar_valid}, 32'd0);
         tick();
      end
      r_valid = 1'b1; r_data = 32'hCAFEF00D;
      chk("t2_r_ready_last", {31'd0, r_ready}, 32'd1);
      tick(); r_data = 32'h55555555;
      chk("t2_r_ready_drop", {31'd0, r_ready}, 32'd0);
      chk("t2_data_cap", data, 32'hCAFEF00D);
      tick();
      chk("t2_done", {31'd0, done}, 32'd1);
      chk("t2_data_once", data, 32'hCAFEF00D);
      chk("t2_ar_address_kept", {28'd0, ar_address}, 32'd9);
      r_valid = 1'b0;

      // T3 error response
      start = 1'b1; addr = 4'h2; ar_ready = 1'b1; r_valid = 1'b1;
      r_data = 32'h0; r_resp = 1'b1;
      tick(); start = 1'b0;
      tick();
      tick();
      chk("t3_resp_proc", {31'd0, resp}, 32'd1);
      chk("t3_err_proc", {31'd0, err}, 32'd0);
      tick();
      chk("t3_done", {31'd0, done}, 32'd1);
      chk("t3_err", {31'd0, err}, 32'd1);
      chk("t3_resp", {31'd0, resp}, 32'd1);
      chk("t3_data", data, 32'h0);
      start = 1'b1; addr = 4'h4; r_resp = 1'b0; ar_ready = 1'b0; r_valid = 1'b0;
      tick();
      chk("t3_err_cleared", {31'd0, err}, 32'd0);
      chk("t3_next_ar_valid", {31'd0, ar_valid}, 32'd1);

      // T4 ignored inputs (start still high, now in SEND_AR)
      addr = 4'h7;
      tick(); start = 1'b0;
      chk("t4_send_hold", {31'd0, ar_valid}, 32'd1);
      chk("t4_addr_hold", {28'd0, ar_address}, 32'd4);
      ar_ready = 1'b1;
      tick(); ar_ready = 1'b0; start = 1'b1; addr = 4'h8;
      chk("t4_wait_r_ready", {31'd0, r_ready}, 32'd1);
      tick(); start = 1'b0;
      chk("t4_wait_hold", {31'd0, r_ready}, 32'd1);
      chk("t4_wait_ar_valid", {31'd0, ar_valid}, 32'd0);
      chk("t4_addr_hold2", {28'd0, ar_address}, 32'd4);
      r_valid = 1'b1; r_data = 32'h11112222;
      tick(); r_valid = 1'b0;
      tick();
      chk("t4_done", {31'd0, done}, 32'd1);
      chk("t4_data", data, 32'h11112222);
      r_valid = 1'b1; r_data = 32'h33334444;
      tick();
      chk("t4_idle_rvalid_done", {31'd0, done}, 32'd1);
      chk("t4_idle_rvalid_r_ready", {31'd0, r_ready}, 32'd0);
      chk("t4_idle_rvalid_data", data, 32'h11112222);
      r_valid = 1'b0;

      // T5 reset mid-op
      start = 1'b1; addr = 4'h6; ar_ready = 1'b1; r_data = 32'h99999999;
      tick(); start = 1'b0;
      tick();
      chk("t5_in_wait", {31'd0, r_ready}, 32'd1);
      rst = 1'b1;
      tick(); rst = 1'b0;
      chk("t5_done", {31'd0, done}, 32'd1);
      chk("t5_r_ready", {31'd0, r_ready}, 32'd0);
      chk("t5_ar_valid", {31'd0, ar_valid}, 32'd0);
      chk("t5_data", data, 32'h0);
      start = 1'b1; addr = 4'hA; r_valid = 1'b1; r_data = 32'hABCD0123;
      tick(); start = 1'b0;
      chk("t5_new_ar_address", {28'd0, ar_address}, 32'd10);
      tick(); tick(); tick();
      chk("t5_new_done", {31'd0, done}, 32'd1);
      chk("t5_new_data", data, 32'hABCD0123);
      r_valid = 1'b0; ar_ready = 1'b0;

      // T6 illegal state
      force dut.state_q = 3'd5;
      #1;
      chk("t6_fsm_error_now", {31'd0, fsm_error}, 32'd1);
      chk("t6_done_now", {31'd0, done}, 32'd0);
      tick();
      release dut.state_q;
      start = 1'b1; ar_ready = 1'b1; r_valid = 1'b1;
      tick(); tick(); tick();
      chk("t6_fsm_error_sticky", {31'd0, fsm_error}, 32'd1);
      chk("t6_ar_valid", {31'd0, ar_valid}, 32'd0);
      chk("t6_r_ready", {31'd0, r_ready}, 32'd0);
      chk("t6_done", {31'd0, done}, 32'd0);
      start = 1'b0; ar_ready = 1'b0; r_valid = 1'b0;
      rst = 1'b1;
      tick(); rst = 1'b0;
      chk("t6_cleared", {31'd0, fsm_error}, 32'd0);
      chk("t6_done_after_rst", {31'd0, done}, 32'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
